// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/forwarding control; optional PC-write tracking under HAZ_PCWRITE_EN
module hazard_ctrl #(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      RA1D,
  input  logic [3:0]      RA2D,
  input  logic [3:0]      WA3D,
  input  logic            RegWriteD,
  input  logic            MemtoRegD,
  input  logic            BranchTakenE,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [CNTW-1:0] LdStallCnt
);
  logic [3:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
  logic       rw_e, rw_m, rw_w, mtr_e, mtr_m;
  logic       ld_use, pc_wr_pend;
  logic       m_ok, a_m, b_m, a_w, b_w;
`ifdef HAZ_PCWRITE_EN
  assign pc_wr_pend = (RegWriteD & WA3D == 4'd15) | (rw_e & wa3_e == 4'd15) | (rw_m & wa3_m == 4'd15);
`else
  assign pc_wr_pend = 1'b0;
`endif
  assign ld_use = mtr_e & rw_e & (wa3_e == RA1D | wa3_e == RA2D);
  // a load in M has no data yet, so only ALU results forward from M
  assign m_ok = rw_m & ~mtr_m;
  assign a_m  = m_ok & wa3_m == ra1_e & ra1_e != 4'd15;
  assign b_m  = m_ok & wa3_m == ra2_e & ra2_e != 4'd15;
  assign a_w  = rw_w & wa3_w == ra1_e & ra1_e != 4'd15;
  assign b_w  = rw_w & wa3_w == ra2_e & ra2_e != 4'd15;
  always_comb begin
    ForwardAE = a_m ? 2'b10 : a_w ? 2'b01 : 2'b00;
    ForwardBE = b_m ? 2'b10 : b_w ? 2'b01 : 2'b00;
    StallF    = ~BranchTakenE & (ld_use | pc_wr_pend);
    StallD    = ~BranchTakenE & ld_use;
    FlushD    = BranchTakenE | pc_wr_pend;
    FlushE    = BranchTakenE | ld_use;
  end
  always_ff @(posedge CLK) begin
    if (RST | FlushE) begin
      ra1_e <= '0;
      ra2_e <= '0;
      wa3_e <= '0;
      rw_e  <= 1'b0;
      mtr_e <= 1'b0;
    end else begin
      ra1_e <= RA1D;
      ra2_e <= RA2D;
      wa3_e <= WA3D;
      rw_e  <= RegWriteD;
      mtr_e <= MemtoRegD;
    end
    if (RST) begin
      wa3_m      <= '0;
      rw_m       <= 1'b0;
      mtr_m      <= 1'b0;
      wa3_w      <= '0;
      rw_w       <= 1'b0;
      LdStallCnt <= '0;
    end else begin
      wa3_m <= wa3_e;
      rw_m  <= rw_e;
      mtr_m <= mtr_e;
      wa3_w <= wa3_m;
      rw_w  <= rw_m;
      if (ld_use & ~BranchTakenE & ~&LdStallCnt) LdStallCnt <= LdStallCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl (default build, CNTW=4)
module tb_hazard_ctrl;
  logic       CLK, RST;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemtoRegD, BranchTakenE;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [3:0] LdStallCnt;
  int checks = 0;
  int errors = 0;
  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;
  exp_t q[$];
  hazard_ctrl #(.CNTW(4)) dut (
    .CLK(CLK), .RST(RST), .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .BranchTakenE(BranchTakenE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .LdStallCnt(LdStallCnt)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  // ctl = {StallF, StallD, FlushD, FlushE}
  task automatic step(input string tag, input logic r, input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] wa3, input logic rw, input logic mtr, input logic br,
                      input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [3:0] cnt);
    exp_t e;
    logic [11:0] obs;
    RST = r; RA1D = ra1; RA2D = ra2; WA3D = wa3;
    RegWriteD = rw; MemtoRegD = mtr; BranchTakenE = br;
    q.push_back('{tag, {ctl, fa, fb, cnt}});
    #3;
    e = q.pop_front();
    obs = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, LdStallCnt};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", e.tag, obs, e.v);
    end
    @(posedge CLK);
    #1;
  endtask
  initial begin
    RST = 1'b1; RA1D = 0; RA2D = 0; WA3D = 0;
    RegWriteD = 0; MemtoRegD = 0; BranchTakenE = 0;
    @(posedge CLK);
    #1;
    step("reset0",     1, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0);
    step("reset1",     1, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 0);
    step("ldr_r3",     0, 1, 2, 3, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 0);
    step("lduse",      0, 1, 3, 4, 1, 0, 0, 4'b1101, 2'b00, 2'b00, 0);
    step("post_stall", 0, 1, 3, 4, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("fwd_b_w",    0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b01, 1);
    step("sub_r5",     0, 0, 0, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("add_r5",     0, 0, 0, 5, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("rd_r5",      0, 5, 4, 6, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("m_over_w",   0, 5, 5, 7, 0, 0, 0, 4'b0000, 2'b10, 2'b00, 1);
    step("w_only",     0, 0, 0, 15, 1, 0, 0, 4'b0000, 2'b01, 2'b01, 1);
    step("rd_r15",     0, 15, 6, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("r15_excl",   0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("ldr_r8",     0, 0, 0, 8, 1, 1, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("br_vs_ld",   0, 8, 0, 9, 1, 0, 1, 4'b0011, 2'b00, 2'b00, 1);
    step("br_bubble",  0, 8, 0, 9, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 1);
    step("rst_mid",    1, 9, 8, 10, 1, 0, 0, 4'b0000, 2'b01, 2'b00, 1);
    step("after_rst",  0, 9, 8, 10, 1, 0, 0, 4'b0000, 2'b00, 2'b00, 0);
    // self-dependent load stalls every other cycle: 20 stalls over 40 cycles
    for (int i = 0; i < 40; i++) begin
      logic lu;
      lu = i[0];
      step($sformatf("sat%0d", i), 0, 3, 0, 3, 1, 1, 0, {lu, lu, 1'b0, lu},
           (lu && i >= 3) ? 2'b01 : 2'b00, 2'b00, (i / 2 > 15) ? 4'd15 : 4'(i / 2));
    end
    step("sat_hold",   0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 2'b00, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
